router_fifo_pkt: RTL and testbench
==================================

// Module: router_fifo_pkt
// PURPOSE
// - Parametrised packet-aware FIFO for one output channel of the 1x3 router; one instance per destination port.
// - Stores {header_flag, byte}. Tracks packet boundaries from the header length field.
// - Adds true full/empty detection, pointer wrap-around and registered read data with a valid strobe.
// - Flags packet-end and truncated-packet events.
// PARAMETERS
// - DATA_W    8   data width in bits.
// - DEPTH     16  number of entries; must be a power of 2 and >= 4.
// - LEN_MSB   7   MSB of the payload-length field inside a header byte.
// - LEN_LSB   2   LSB of the payload-length field inside a header byte.
// PORTS
// - clk         in   1       rising-edge clock.
// - reset       in   1       synchronous, active-high reset.
// - soft_reset  in   1       synchronous, active-high flush (channel timeout from the FSM).
// - write_enb   in   1       write request.
// - lfd_state   in   1       high = data_in is a header byte; stored as the entry's flag bit.
// - data_in     in   DATA_W  write data.
// - read_enb    in   1       read request.
// - data_out    out  DATA_W  registered read data.
// - data_valid  out  1       data_out is updated this cycle.
// - empty       out  1       occupancy == 0.
// - full        out  1       occupancy == DEPTH.
// - pkt_done    out  1       1-cycle pulse with the last byte of a packet (parity byte).
// - pkt_err     out  1       1-cycle pulse when a header is read before the prior packet has completed.
// BEHAVIOUR
// - Storage: DEPTH x (DATA_W+1). Pointers are log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
//   - empty: pointers are equal.
//   - full: addresses are equal and the wrap bits differ.
// - Write is accepted iff write_enb && !full (full as at the start of the cycle).
//   - Stores {lfd_state, data_in} and advances wr_ptr.
// - Read is accepted iff read_enb && !empty (empty as at the start of the cycle).
//   - Advances rd_ptr.
//   - The next cycle shows data_out = entry[DATA_W-1:0] with data_valid = 1.
// - Read latency is exactly 1 cycle.
//   - data_out holds its last value when no read occurs.
//   - data_valid is otherwise 0.
// - Simultaneous write and read:
//   - Both are accepted when neither full nor empty; occupancy is unchanged.
//   - When full, only the read is accepted.
//   - When empty, only the write is accepted (no write-through).
// - Packet tracking uses the remaining-byte counter rem, of width (LEN_MSB-LEN_LSB+2).
//   - Accepted read of a header entry: rem <= len + 1 (payload plus parity).
//     - If rem != 0 at that moment, pkt_err pulses with that byte's data_valid.
//   - Accepted read of a non-header entry with rem != 0: rem decrements.
//     - When rem goes from 1 to 0, pkt_done pulses with that byte's data_valid.
//   - A non-header read with rem == 0 is an orphan byte: it is read normally, rem stays 0 and no pulse is issued.
//   - A header with len = 0 gives rem = 1, so the following parity byte raises pkt_done.
// - reset or soft_reset (highest priority; any read or write in the same cycle is ignored):
//   - pointers = 0, rem = 0, data_out = 0.
//   - data_valid, pkt_done and pkt_err = 0.
//   - empty = 1, full = 0 on the following cycle.
// - Memory contents are not cleared on reset or flush.
// - Asserting reset or soft_reset mid-packet discards the stored bytes. The first read after the flush must be a header, otherwise it is an orphan.
// CONFIGURATION
// - ROUTER_FIFO_OCCUPANCY_EN defined:
//   - Adds output occupancy [log2(DEPTH):0]: the registered entry count, updated the same cycle as the pointers and cleared by reset or soft_reset.
//   - Adds output almost_full: asserted when occupancy >= DEPTH-2.
// - ROUTER_FIFO_OCCUPANCY_EN undefined: neither port exists and no count register is built. All other behaviour is identical.
// TESTING
// - reset for 2 cycles -> empty=1, full=0, data_out=8'h00, data_valid=0, pkt_done=0.
// - Write header 8'h0C (len=3) with lfd=1, then 8'hA1, 8'hA2, 8'hA3, parity 8'h5E; read 5 -> data_out sequence 0C,A1,A2,A3,5E, each 1 cycle after its read, with pkt_done only on 5E.
// - Write 16 bytes -> full=1. A 17th write is dropped. Read 16 -> data back in order, empty=1. Repeat 3 times to exercise wrap-around.
// - Full FIFO with write_enb=read_enb=1 -> read accepted, write dropped, full deasserts. Empty FIFO with both asserted -> write accepted, data_valid=0.
// - Header 8'h10 (len=4), read 2 bytes, then read a new header 8'h04 -> pkt_err pulse; rem reloads to 2 and pkt_done follows 2 reads later.
// - soft_reset asserted with 6 entries while write_enb=1 -> next cycle empty=1, write ignored. ROUTER_FIFO_OCCUPANCY_EN build: occupancy=0; with 14 entries almost_full=1.

Source files
------------

// File: rtl/router_fifo_pkt_if.sv
// Handshake and status bundle for one router_fifo_pkt output channel.
// ROUTER_FIFO_OCCUPANCY_EN adds the occupancy and almost_full signals.
interface router_fifo_pkt_if #(
    parameter int DATA_W = 8
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    ,
    parameter int DEPTH  = 16
`endif
);
    logic              write_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              empty;
    logic              full;
    logic              pkt_done;
    logic              pkt_err;
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    logic [$clog2(DEPTH):0] occupancy;
    logic                   almost_full;
`endif

    // Producer/consumer side: router FSM or test driver.
    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, data_valid, empty, full, pkt_done, pkt_err
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        ,
        input  occupancy, almost_full
`endif
    );

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, data_valid, empty, full, pkt_done, pkt_err
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        ,
        output occupancy, almost_full
`endif
    );
endinterface

// File: rtl/router_fifo_pkt.sv
// Packet-aware FIFO for one router output channel: {header_flag, byte} storage,
// registered read data, packet-end / truncation pulses. Option: ROUTER_FIFO_OCCUPANCY_EN.
module router_fifo_pkt #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int LEN_MSB = 7,
    parameter int LEN_LSB = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 soft_reset,
    router_fifo_pkt_if.slave     bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
    localparam int REM_W = LEN_W + 1;

    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    logic [DATA_W:0]      mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [REM_W-1:0]     rem;
    logic [DATA_W-1:0]    data_out_q;
    logic                 data_valid_q;
    logic                 pkt_done_q;
    logic                 pkt_err_q;

    logic                 flush;
    logic                 empty_c;
    logic                 full_c;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [DATA_W:0]      rd_entry;
    logic                 rd_hdr;
    logic [LEN_W-1:0]     rd_len;

    // Pointers carry an extra wrap bit so equal addresses can mean full or empty.
    assign flush    = reset | soft_reset;
    assign empty_c  = (wr_ptr == rd_ptr);
    assign full_c   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_ok    = bus.write_enb && !full_c;
    assign rd_ok    = bus.read_enb && !empty_c;
    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign rd_hdr   = rd_entry[DATA_W];
    assign rd_len   = rd_entry[LEN_MSB:LEN_LSB];

    // NOTE: the storage array has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    // NOTE: non-blocking assignments so every register here sees pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rem          <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_err_q    <= 1'b0;
        end else begin
            data_valid_q <= rd_ok;
            pkt_done_q   <= 1'b0;
            pkt_err_q    <= 1'b0;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                data_out_q <= rd_entry[DATA_W-1:0];
                if (rd_hdr) begin
                    // Header reload counts payload plus the trailing parity byte.
                    rem       <= REM_W'(rd_len) + REM_ONE;
                    pkt_err_q <= (rem != '0);
                end else if (rem != '0) begin
                    rem        <= rem - REM_ONE;
                    pkt_done_q <= (rem == REM_ONE);
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.empty      = empty_c;
    assign bus.full       = full_c;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.pkt_err    = pkt_err_q;

`ifdef ROUTER_FIFO_OCCUPANCY_EN
    localparam logic [AW:0] AF_LVL = (AW + 1)'(DEPTH - 2);

    logic [AW:0] occ_q;

    always_ff @(posedge clk) begin
        if (flush) begin
            occ_q <= '0;
        end else if (wr_ok && !rd_ok) begin
            occ_q <= occ_q + PTR_ONE;
        end else if (rd_ok && !wr_ok) begin
            occ_q <= occ_q - PTR_ONE;
        end
    end

    assign bus.occupancy   = occ_q;
    assign bus.almost_full = (occ_q >= AF_LVL);
`endif
endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed self-checking bench for router_fifo_pkt (default build and ROUTER_FIFO_OCCUPANCY_EN).
module tb_router_fifo_pkt;
    logic clk = 1'b0;
    logic reset;
    logic soft_reset;
    int   errors = 0;
    int   checks = 0;

`ifdef ROUTER_FIFO_OCCUPANCY_EN
    router_fifo_pkt_if #(.DATA_W(8), .DEPTH(16)) f ();
`else
    router_fifo_pkt_if #(.DATA_W(8)) f ();
`endif

    router_fifo_pkt #(
        .DATA_W (8),
        .DEPTH  (16),
        .LEN_MSB(7),
        .LEN_LSB(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .soft_reset(soft_reset),
        .bus       (f.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic hdr);
        f.write_enb = 1'b1;
        f.lfd_state = hdr;
        f.data_in   = d;
        tick();
        f.write_enb = 1'b0;
        f.lfd_state = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp_d, input logic exp_done,
                       input logic exp_err);
        f.read_enb = 1'b1;
        tick();
        f.read_enb = 1'b0;
        check({tag, ".valid"}, 32'(f.data_valid), 32'(1'b1));
        check({tag, ".data"}, 32'(f.data_out), 32'(exp_d));
        check({tag, ".done"}, 32'(f.pkt_done), 32'(exp_done));
        check({tag, ".err"}, 32'(f.pkt_err), 32'(exp_err));
    endtask

    initial begin
        logic [7:0] d;
        reset        = 1'b1;
        soft_reset   = 1'b0;
        f.write_enb  = 1'b0;
        f.lfd_state  = 1'b0;
        f.data_in    = '0;
        f.read_enb   = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst.empty", 32'(f.empty), 1);
        check("rst.full", 32'(f.full), 0);
        check("rst.data", 32'(f.data_out), 0);
        check("rst.valid", 32'(f.data_valid), 0);
        check("rst.done", 32'(f.pkt_done), 0);
        check("rst.err", 32'(f.pkt_err), 0);
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        check("rst.occ", 32'(f.occupancy), 0);
`endif

        // One complete packet: header len=3 + 3 payload + parity
        push(8'h0C, 1'b1);
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b0);
        push(8'h5E, 1'b0);
        check("pkt.nonempty", 32'(f.empty), 0);
        pop("pkt0", 8'h0C, 1'b0, 1'b0);
        pop("pkt1", 8'hA1, 1'b0, 1'b0);
        pop("pkt2", 8'hA2, 1'b0, 1'b0);
        pop("pkt3", 8'hA3, 1'b0, 1'b0);
        pop("pkt4", 8'h5E, 1'b1, 1'b0);
        tick();
        check("idle.valid", 32'(f.data_valid), 0);
        check("idle.hold", 32'(f.data_out), 32'h5E);
        check("idle.done", 32'(f.pkt_done), 0);
        check("pkt.empty", 32'(f.empty), 1);

        // Fill / overflow / drain three times to wrap the pointers
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                d = 8'(r * 16 + i);
                push(d, 1'b0);
            end
            check($sformatf("wrap%0d.full", r), 32'(f.full), 1);
            check($sformatf("wrap%0d.nempty", r), 32'(f.empty), 0);
            push(8'hFF, 1'b0);
            check($sformatf("wrap%0d.full17", r), 32'(f.full), 1);
            for (int i = 0; i < 16; i++) begin
                d = 8'(r * 16 + i);
                pop($sformatf("wrap%0d.rd%0d", r, i), d, 1'b0, 1'b0);
            end
            check($sformatf("wrap%0d.empty", r), 32'(f.empty), 1);
            check($sformatf("wrap%0d.nfull", r), 32'(f.full), 0);
        end

        // Simultaneous read/write while full: only the read is taken
        for (int i = 0; i < 16; i++) begin
            d = 8'(8'h40 + i);
            push(d, 1'b0);
        end
        f.write_enb = 1'b1;
        f.data_in   = 8'hEE;
        f.read_enb  = 1'b1;
        tick();
        f.write_enb = 1'b0;
        f.read_enb  = 1'b0;
        check("rwfull.valid", 32'(f.data_valid), 1);
        check("rwfull.data", 32'(f.data_out), 32'h40);
        check("rwfull.full", 32'(f.full), 0);
        for (int i = 1; i < 16; i++) begin
            d = 8'(8'h40 + i);
            pop($sformatf("rwfull.rd%0d", i), d, 1'b0, 1'b0);
        end
        check("rwfull.drained", 32'(f.empty), 1);

        // Simultaneous read/write while empty: only the write is taken
        f.write_enb = 1'b1;
        f.data_in   = 8'h77;
        f.read_enb  = 1'b1;
        tick();
        f.write_enb = 1'b0;
        f.read_enb  = 1'b0;
        check("rwempty.valid", 32'(f.data_valid), 0);
        check("rwempty.hold", 32'(f.data_out), 32'h4F);
        check("rwempty.nempty", 32'(f.empty), 0);
        pop("rwempty.rd", 8'h77, 1'b0, 1'b0);
        check("rwempty.empty", 32'(f.empty), 1);

        // Truncated packet: header len=4, one payload byte, then header len=1
        push(8'h10, 1'b1);
        push(8'hB1, 1'b0);
        push(8'h04, 1'b1);
        push(8'hC1, 1'b0);
        push(8'hC2, 1'b0);
        pop("trunc.h0", 8'h10, 1'b0, 1'b0);
        pop("trunc.b1", 8'hB1, 1'b0, 1'b0);
        pop("trunc.h1", 8'h04, 1'b0, 1'b1);
        pop("trunc.c1", 8'hC1, 1'b0, 1'b0);
        pop("trunc.c2", 8'hC2, 1'b1, 1'b0);

        // Zero-length packet: header then parity completes it
        push(8'h01, 1'b1);
        push(8'h99, 1'b0);
        pop("len0.h", 8'h01, 1'b0, 1'b0);
        pop("len0.p", 8'h99, 1'b1, 1'b0);

`ifdef ROUTER_FIFO_OCCUPANCY_EN
        // Occupancy and almost_full threshold
        for (int i = 0; i < 13; i++) begin
            d = 8'(i);
            push(d, 1'b0);
        end
        check("occ.13", 32'(f.occupancy), 13);
        check("af.13", 32'(f.almost_full), 0);
        push(8'h0D, 1'b0);
        check("occ.14", 32'(f.occupancy), 14);
        check("af.14", 32'(f.almost_full), 1);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("occ.flush", 32'(f.occupancy), 0);
        check("af.flush", 32'(f.almost_full), 0);
        check("occ.empty", 32'(f.empty), 1);
`endif

        // Mid-packet flush with 6 entries left and a concurrent write/read
        push(8'h0C, 1'b1);
        push(8'h11, 1'b0);
        push(8'h12, 1'b0);
        push(8'h13, 1'b0);
        push(8'h14, 1'b0);
        push(8'h08, 1'b1);
        push(8'h21, 1'b0);
        push(8'h22, 1'b0);
        pop("sr.h", 8'h0C, 1'b0, 1'b0);
        pop("sr.b", 8'h11, 1'b0, 1'b0);
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        check("sr.occ6", 32'(f.occupancy), 6);
`endif
        soft_reset  = 1'b1;
        f.write_enb = 1'b1;
        f.data_in   = 8'hDD;
        f.read_enb  = 1'b1;
        tick();
        soft_reset  = 1'b0;
        f.write_enb = 1'b0;
        f.read_enb  = 1'b0;
        check("sr.empty", 32'(f.empty), 1);
        check("sr.full", 32'(f.full), 0);
        check("sr.valid", 32'(f.data_valid), 0);
        check("sr.data", 32'(f.data_out), 0);
        check("sr.done", 32'(f.pkt_done), 0);
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        check("sr.occ", 32'(f.occupancy), 0);
`endif
        // Orphan bytes after the flush: remaining count must have been cleared
        push(8'h33, 1'b0);
        push(8'h34, 1'b0);
        push(8'h35, 1'b0);
        pop("orph0", 8'h33, 1'b0, 1'b0);
        pop("orph1", 8'h34, 1'b0, 1'b0);
        pop("orph2", 8'h35, 1'b0, 1'b0);
        push(8'h04, 1'b1);
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        pop("post.h", 8'h04, 1'b0, 1'b0);
        pop("post.b", 8'h55, 1'b0, 1'b0);
        pop("post.p", 8'h66, 1'b1, 1'b0);

        // Hard reset while a write is requested
        push(8'h12, 1'b0);
        reset       = 1'b1;
        f.write_enb = 1'b1;
        f.data_in   = 8'h9A;
        tick();
        tick();
        reset       = 1'b0;
        f.write_enb = 1'b0;
        check("hr.empty", 32'(f.empty), 1);
        check("hr.data", 32'(f.data_out), 0);
        check("hr.valid", 32'(f.data_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
